// File: rtl/ps2_pkg.sv
// Shared types and default parameters for the PS/2 receiver with output FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       parity_err;
        logic [7:0] data;
    } fifo_entry_t;

    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_FILTER_LEN     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 10000;

endpackage

// File: rtl/ps2_filter.sv
// Synchronises the raw PS/2 lines, debounces ps2_clk and emits a one-cycle
// pulse on each filtered falling edge together with the data bit seen then.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic fall_bit
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;
    logic          bit_q, bit_d;

    // The filtered level flips only after FILTER_LEN samples in a row disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_s2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = filt_q && !filt_d;
        bit_d  = dat_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
            bit_q    <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
            bit_q    <= bit_d;
        end
    end

    assign fall     = fall_q;
    assign fall_bit = bit_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver (start, 8 data LSB-first, odd parity, stop) feeding a
// small FIFO with a sticky overflow flag and a frame-error pulse.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_data,
    output logic       out_parity_err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       frame_err,
    input  logic       clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic filt_fall, filt_bit;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (filt_fall),
        .fall_bit (filt_bit)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_err_q, parity_err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          push_q, push_d;
    fifo_entry_t   push_entry_q, push_entry_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_err_d = parity_err_q;
        frame_err_d  = 1'b0;
        push_d       = 1'b0;
        push_entry_d = push_entry_q;
        if (state_q == IDLE || filt_fall) tmo_d = '0;
        else                              tmo_d = tmo_q + TW'(1);

        if (filt_fall) begin
            case (state_q)
                IDLE: begin
                    if (!filt_bit) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d   = {filt_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_err_d = ~(^{shift_q, filt_bit});
                    state_d      = STOP;
                end
                STOP: begin
                    if (filt_bit) begin
                        push_d       = 1'b1;
                        push_entry_d = '{parity_err: parity_err_q, data: shift_q};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // Sender went quiet mid-frame: drop the partial frame.
            state_d     = IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_err_q <= 1'b0;
            tmo_q        <= '0;
            frame_err_q  <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_err_q <= parity_err_d;
            tmo_q        <= tmo_d;
            frame_err_q  <= frame_err_d;
            push_q       <= push_d;
            push_entry_q <= push_entry_d;
        end
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        fifo_empty, fifo_full, pop, wr_en, ovf_set;
    fifo_entry_t mem_q [FIFO_DEPTH];

    // Full when the wrap bits differ but the slot indices coincide.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && out_ready;
        wr_en      = push_q && (!fifo_full || pop);
        ovf_set    = push_q && fifo_full && !pop;
        wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        if (ovf_set)    overflow_d = 1'b1;
        else if (clear) overflow_d = 1'b0;
        else            overflow_d = overflow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_q;
    end

    assign out_data       = mem_q[rd_ptr_q[AW-1:0]].data;
    assign out_parity_err = mem_q[rd_ptr_q[AW-1:0]].parity_err;
    assign out_valid      = !fifo_empty;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames plus random traffic against a
// queue-based model of received bytes.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, out_ready, clear;
    logic [7:0] out_data;
    logic       out_parity_err, out_valid, overflow, frame_err;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .frame_err      (frame_err),
        .clear          (clear)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    int         exp_err  = 0;
    int         cyc = 0, err_cnt = 0, err_cyc = -1, last_fall_cyc = -1, valid_rise_cyc = -1;
    int         pop_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the model queue whenever the DUT hands over a byte.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (dut.filt_fall) last_fall_cyc = cyc;
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_when_model_empty", {23'd0, out_parity_err, out_data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("pop_data", out_data, e[7:0]);
                    check("pop_parity_err", out_parity_err, e[8]);
                    pop_cnt++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cycles(2);
        ps2_clk = 1'b0;
        cycles(4);
        ps2_clk = 1'b1;
        cycles(2);
    endtask

    // Model: a good stop bit yields a byte if the FIFO has room; parity error
    // means the nine received bits hold an even number of ones.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        if (stop) begin
            if (exp_q.size() < DEPTH)
                exp_q.push_back({1'($countones({d, par}) % 2 == 0), d});
        end else begin
            exp_err++;
        end
        send_bit(stop);
        ps2_data = 1'b1;
        cycles(8);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            cycles(1);
            n++;
        end
        check(name, 32'(exp_q.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        int e0, p0, lat, n;
        logic [7:0] d;
        logic       par, stop;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0; clear = 1'b0;
        cycles(3);
        check("reset_out_valid", out_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        cycles(5);

        // 0xA5 with correct parity and its output latency
        out_ready = 1'b1;
        e0 = err_cnt; p0 = pop_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        drain("a5_drain");
        check("a5_popped", pop_cnt - p0, 1);
        check("a5_valid_latency", 32'(valid_rise_cyc - last_fall_cyc), 2);

        // 0x3C has four ones, so parity bit 0 is the wrong one
        send_frame(8'h3C, 1'b0, 1'b1);
        drain("3c_drain");
        check("3c_no_frame_err", err_cnt - e0, 0);

        // Overflow with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), ~^8'(i), 1'b1);
        check("ovf_set", overflow, 1);
        check("ovf_model_full", exp_q.size(), DEPTH);
        p0 = pop_cnt;
        out_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_popped_four", pop_cnt - p0, 4);
        check("ovf_sticky", overflow, 1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Short glitch on idle ps2_clk
        e0 = err_cnt; lat = last_fall_cyc;
        ps2_clk = 1'b0;
        cycles(2);
        ps2_clk = 1'b1;
        cycles(20);
        check("glitch_no_fall", 32'(last_fall_cyc), 32'(lat));
        check("glitch_no_frame_err", err_cnt - e0, 0);
        check("glitch_state", 32'(dut.state_q), 32'(IDLE));

        // Partial frame then silence -> timeout abort
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
        n = 0;
        while (err_cnt == e0 && n < 300) begin
            cycles(1);
            n++;
        end
        check("timeout_seen", err_cnt - e0, 1);
        lat = err_cyc - last_fall_cyc;
        check("timeout_latency_in_window", 32'(lat >= TMO && lat <= TMO + 1), 1);
        check("timeout_state", 32'(dut.state_q), 32'(IDLE));
        p0 = pop_cnt;
        send_frame(8'h7E, 1'b1, 1'b1);
        drain("7e_drain");
        check("7e_popped", pop_cnt - p0, 1);

        // Bad stop bit
        e0 = err_cnt; exp_err = 0;
        send_frame(8'h55, 1'b1, 1'b0);
        cycles(5);
        check("badstop_frame_err", err_cnt - e0, exp_err);
        check("badstop_no_output", out_valid, 0);

        // Reset mid-frame with a byte already queued
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        check("rst_pre_valid", out_valid, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        cycles(3);
        exp_q.delete();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        ps2_data = 1'b1;
        cycles(5);
        check("rst_post_valid", out_valid, 0);

        // Random traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        e0 = err_cnt; exp_err = 0;
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, par, stop);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        check("rand_frame_errs", err_cnt - e0, exp_err);
        check("rand_no_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish, bound 2000000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
